// File: rtl/lsb_rbs_pipe.sv
`timescale 1ns/1ps
// Four-stage pipelined 16-bit ripple-borrow subtractor, D = A - B - B_in.
// One 4-bit slice per stage, LSB slice first; borrow ripples through stage registers.
module lsb_rbs_pipe (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        B_in,
   input  logic        IN_VALID,
   output logic        IN_READY,
   output logic [15:0] D,
   output logic        B_out,
   output logic        V,
   output logic        OUT_VALID,
   input  logic        OUT_READY
);

   // Handshake: a transfer happens on any rising edge where valid & ready are both
   // high; IN_READY = !OUT_VALID | OUT_READY and never looks at IN_VALID.
   logic        en;
   logic [3:0]  vld_q, vld_d;
   logic [3:0]  nb_q, nb_d;
   logic [4:0]  sl0, sl1, sl2, sl3;

   // Skew registers: unprocessed upper operand slices, completed lower result slices.
   logic [15:4]  a0_q, a0_d, b0_q, b0_d;
   logic [3:0]   d0_q, d0_d;
   logic [15:8]  a1_q, a1_d, b1_q, b1_d;
   logic [7:0]   d1_q, d1_d;
   logic [15:12] a2_q, a2_d, b2_q, b2_d;
   logic [11:0]  d2_q, d2_d;
   logic         a3_q, a3_d, b3_q, b3_d;
   logic [15:0]  d3_q, d3_d;

   function automatic logic [4:0] sub_slice(input logic [3:0] a, input logic [3:0] b,
                                            input logic bin);
      return {1'b0, a} - {1'b0, b} - {4'b0000, bin};
   endfunction

   assign en       = !vld_q[3] | OUT_READY;
   assign IN_READY = en;

   always_comb begin
      sl0 = sub_slice(A[3:0], B[3:0], B_in);
      sl1 = sub_slice(a0_q[7:4], b0_q[7:4], nb_q[0]);
      sl2 = sub_slice(a1_q[11:8], b1_q[11:8], nb_q[1]);
      sl3 = sub_slice(a2_q[15:12], b2_q[15:12], nb_q[2]);

      vld_d = {vld_q[2:0], IN_VALID};
      nb_d  = {sl3[4], sl2[4], sl1[4], sl0[4]};

      a0_d = A[15:4];
      b0_d = B[15:4];
      d0_d = sl0[3:0];
      a1_d = a0_q[15:8];
      b1_d = b0_q[15:8];
      d1_d = {sl1[3:0], d0_q};
      a2_d = a1_q[15:12];
      b2_d = b1_q[15:12];
      d2_d = {sl2[3:0], d1_q};
      a3_d = a2_q[15];
      b3_d = b2_q[15];
      d3_d = {sl3[3:0], d2_q};
   end

   // Whole pipeline advances together; nothing moves while the output is held.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q <= '0;
         nb_q  <= '0;
         a0_q  <= '0;
         b0_q  <= '0;
         d0_q  <= '0;
         a1_q  <= '0;
         b1_q  <= '0;
         d1_q  <= '0;
         a2_q  <= '0;
         b2_q  <= '0;
         d2_q  <= '0;
         a3_q  <= 1'b0;
         b3_q  <= 1'b0;
         d3_q  <= '0;
      end else if (en) begin
         vld_q <= vld_d;
         nb_q  <= nb_d;
         a0_q  <= a0_d;
         b0_q  <= b0_d;
         d0_q  <= d0_d;
         a1_q  <= a1_d;
         b1_q  <= b1_d;
         d1_q  <= d1_d;
         a2_q  <= a2_d;
         b2_q  <= b2_d;
         d2_q  <= d2_d;
         a3_q  <= a3_d;
         b3_q  <= b3_d;
         d3_q  <= d3_d;
      end
   end

   assign D         = d3_q;
   assign B_out     = nb_q[3];
   assign OUT_VALID = vld_q[3];
   assign V         = (a3_q ^ b3_q) & (d3_q[15] ^ a3_q);

endmodule

// File: tb/tb_lsb_rbs_pipe.sv
`timescale 1ns/1ps
// Bench for lsb_rbs_pipe: directed vectors, expected queue, decoupled output monitor.
module tb_lsb_rbs_pipe;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] A, B;
   logic        B_in, IN_VALID, IN_READY;
   logic [15:0] D;
   logic        B_out, V, OUT_VALID, OUT_READY;

   int          checks = 0;
   int          errors = 0;
   int          stall_seen = 0;
   logic [17:0] exp_q[$];
   logic        held = 1'b0;
   logic [17:0] held_val = '0;

   lsb_rbs_pipe dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .B_in(B_in),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .D(D), .B_out(B_out), .V(V),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: samples mid-cycle, pops the expected queue on every transfer.
   always @(negedge CLK) begin
      if (RST) begin
         held = 1'b0;
      end else begin
         chk("in_ready", {31'd0, IN_READY}, {31'd0, !(OUT_VALID && !OUT_READY)});
         if (!IN_READY) stall_seen++;
         if (held) begin
            chk("hold_valid", {31'd0, OUT_VALID}, 32'd1);
            chk("hold_data", {14'd0, D, B_out, V}, {14'd0, held_val});
         end
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %h expected none", {D, B_out, V});
            end else begin
               chk("result", {14'd0, D, B_out, V}, {14'd0, exp_q.pop_front()});
            end
         end
         held     = OUT_VALID && !OUT_READY;
         held_val = {D, B_out, V};
      end
   end

   // Called at posedge+1; returns at posedge+1 after the operation was captured.
   task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                       input logic [17:0] exp, input bit track);
      int w;
      A = a; B = b; B_in = bin; IN_VALID = 1'b1;
      w = 0;
      @(negedge CLK);
      while (!IN_READY && w < 50) begin
         @(negedge CLK);
         w++;
      end
      if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
      if (track) exp_q.push_back(exp);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
   endtask

   // Pipeline must be empty and OUT_READY high on entry.
   task automatic lat_check(input logic [15:0] a, input logic [15:0] b, input logic bin,
                            input logic [17:0] exp);
      A = a; B = b; B_in = bin; IN_VALID = 1'b1;
      @(negedge CLK);
      chk("lat_accept", {31'd0, IN_READY}, 32'd1);
      exp_q.push_back(exp);
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge CLK);
         chk("lat_early", {31'd0, OUT_VALID}, 32'd0);
      end
      @(negedge CLK);
      chk("lat_out", {31'd0, OUT_VALID}, 32'd1);
      @(negedge CLK);
      chk("one_cycle", {31'd0, OUT_VALID}, 32'd0);
      @(posedge CLK); #1;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge CLK);
         t++;
      end
      #1;
      chk("drain", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   logic [15:0] st_a[6] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060};
   logic [15:0] st_b[6] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006};
   logic [15:0] st_d[6] = '{16'h000F, 16'h001E, 16'h002D, 16'h003C, 16'h004B, 16'h005A};

   initial begin
      RST = 1'b1; A = '0; B = '0; B_in = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      chk("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("rst_d", {16'd0, D}, 32'h0000);
      chk("rst_b_out", {31'd0, B_out}, 32'd0);
      chk("rst_v", {31'd0, V}, 32'd0);
      chk("rst_in_ready", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK); #1;

      // Latency 4, plus full borrow ripple through all slices.
      lat_check(16'h1234, 16'h0234, 1'b0, {16'h1000, 1'b0, 1'b0});
      lat_check(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 1'b1, 1'b0});

      send(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 1'b0, 1'b1}, 1'b1);
      send(16'h0000, 16'h0000, 1'b1, {16'hFFFF, 1'b1, 1'b0}, 1'b1);
      send(16'h7FFF, 16'hFFFF, 1'b0, {16'h8000, 1'b1, 1'b1}, 1'b1);
      send(16'hFFFF, 16'hFFFF, 1'b1, {16'hFFFF, 1'b1, 1'b0}, 1'b1);
      send(16'hA5A5, 16'h5A5A, 1'b0, {16'h4B4B, 1'b0, 1'b1}, 1'b1);
      drain();

      // Back-to-back stream with a 3-cycle consumer stall in the middle.
      stall_seen = 0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(st_a[i], st_b[i], 1'b0, {st_d[i], 1'b0, 1'b0}, 1'b1);
         end
         begin
            idle(5);
            OUT_READY = 1'b0;
            idle(3);
            OUT_READY = 1'b1;
         end
      join
      drain();
      chk("stall_cycles", 32'(stall_seen), 32'd3);

      // Reset with three operations in flight: none may ever emerge.
      send(16'h1111, 16'h0001, 1'b0, '0, 1'b0);
      send(16'h2222, 16'h0002, 1'b0, '0, 1'b0);
      send(16'h3333, 16'h0003, 1'b0, '0, 1'b0);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
      chk("mid_rst_d", {16'd0, D}, 32'h0000);
      chk("mid_rst_in_ready", {31'd0, IN_READY}, 32'd1);
      @(posedge CLK); #1;
      idle(8);

      // Pipeline still works after the mid-flight reset.
      send(16'h0100, 16'h0001, 1'b0, {16'h00FF, 1'b0, 1'b0}, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
